// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared defines for the EX/MEM pipeline register.
//   Bus widths, reset/no-op constants, the per-edge action encoding and the
//   packed payload carried from execute to memory (plus madd/msub feedback).
package ex_mem_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned CntBus       = 2;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = RegAddrBus'(0);
  localparam logic [RegBus-1:0]     ZeroWord   = RegBus'(0);

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  // Non-reset action applied at a clock edge (reset is handled in the flop).
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_PASS,
    ACT_HOLD
  } ex_mem_act_e;

  // Registered EX/MEM payload.
  typedef struct packed {
    logic [RegAddrBus-1:0]   wd;
    logic                    wreg;
    logic [RegBus-1:0]       wdata;
    logic                    whilo;
    logic [RegBus-1:0]       hi;
    logic [RegBus-1:0]       lo;
    logic [DoubleRegBus-1:0] hilo;
    logic [CntBus-1:0]       cnt;
  } ex_mem_bus_t;

  // Value loaded on reset and on flush; a bubble starts from it as well.
  localparam ex_mem_bus_t BusReset = '{
    wd:    NOPRegAddr,
    wreg:  WriteDisable,
    wdata: ZeroWord,
    whilo: WriteDisable,
    hi:    ZeroWord,
    lo:    ZeroWord,
    hilo:  DoubleRegBus'(0),
    cnt:   CntBus'(0)
  };

endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
//   Registers the execute-stage GPR and HI/LO write fields for the memory
//   stage, and loops the multi-cycle madd/msub partial product and count back
//   to execute while execute is stalled.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             per-stage stall vector (EX_IDX = execute, MEM_IDX = memory)
//   flush             pipeline flush, present only when EX_MEM_FLUSH_EN is defined
//   ex_wd/wreg/wdata  execute GPR destination, write enable, result
//   ex_whilo/hi/lo    execute HI/LO write enable and values
//   hilo_i, cnt_i     madd/msub partial product and cycle count from execute
//   mem_*             registered GPR and HI/LO fields to memory
//   hilo_o, cnt_o     registered partial product and count back to execute
// Configuration: define EX_MEM_FLUSH_EN to add the flush port and the flush
//   action (priority RESET > FLUSH > BUBBLE > PASS > HOLD).
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = 3,
  parameter int unsigned MEM_IDX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic                    ex_whilo,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic                    mem_whilo,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  ex_mem_act_e act;
  ex_mem_bus_t bus_d;
  ex_mem_bus_t bus_q;

  // Action decode: execute stalled with memory running inserts a bubble.
  always_comb begin
    act = ACT_HOLD;
`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      act = ACT_FLUSH;
    end else
`endif
    if (stall[EX_IDX] == Stop && stall[MEM_IDX] == NoStop) begin
      act = ACT_BUBBLE;
    end else if (stall[EX_IDX] == NoStop) begin
      act = ACT_PASS;
    end
  end

  // Next-state select for the single register bank.
  always_comb begin
    bus_d = bus_q;
    case (act)
      ACT_FLUSH: bus_d = BusReset;
      ACT_BUBBLE: begin
        // Memory sees a no-op, but the madd/msub accumulation keeps cycling.
        bus_d      = BusReset;
        bus_d.hilo = hilo_i;
        bus_d.cnt  = cnt_i;
      end
      ACT_PASS: begin
        // Instruction advances, so the madd/msub feedback restarts from zero.
        bus_d = '{
          wd:    ex_wd,
          wreg:  ex_wreg,
          wdata: ex_wdata,
          whilo: ex_whilo,
          hi:    ex_hi,
          lo:    ex_lo,
          hilo:  DoubleRegBus'(0),
          cnt:   CntBus'(0)
        };
      end
      default: bus_d = bus_q;
    endcase
  end

  // Register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bus_q <= BusReset;
    end else begin
      bus_q <= bus_d;
    end
  end

  assign mem_wd    = bus_q.wd;
  assign mem_wreg  = bus_q.wreg;
  assign mem_wdata = bus_q.wdata;
  assign mem_whilo = bus_q.whilo;
  assign mem_hi    = bus_q.hi;
  assign mem_lo    = bus_q.lo;
  assign hilo_o    = bus_q.hilo;
  assign cnt_o     = bus_q.cnt;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: scoreboard bench for ex_mem. A driver applies directed and random
// stimulus on the falling edge and queues the outputs expected after the next
// rising edge; a monitor pops and compares after every rising edge.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t model;
  exp_t e_mon;
  exp_t a_mon;
  bit   driving_done = 1'b0;

  ex_mem dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
`ifdef EX_MEM_FLUSH_EN
    .flush    (flush),
`endif
    .ex_wd    (ex_wd),
    .ex_wreg  (ex_wreg),
    .ex_wdata (ex_wdata),
    .ex_whilo (ex_whilo),
    .ex_hi    (ex_hi),
    .ex_lo    (ex_lo),
    .hilo_i   (hilo_i),
    .cnt_i    (cnt_i),
    .mem_wd   (mem_wd),
    .mem_wreg (mem_wreg),
    .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo),
    .mem_hi   (mem_hi),
    .mem_lo   (mem_lo),
    .hilo_o   (hilo_o),
    .cnt_o    (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic f, input logic [5:0] s,
                      input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                      input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                      input logic [63:0] hl, input logic [1:0] cn);
    bit flushing;
    @(negedge clk);
    rst = r; flush = f; stall = s;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
    hilo_i = hl; cnt_i = cn;
    flushing = 1'b0;
`ifdef EX_MEM_FLUSH_EN
    flushing = f;
`endif
    if (r) begin
      model = '0;
    end else if (flushing) begin
      model = '0;
    end else if (!s[3]) begin
      model = '{wd, wreg, wdata, whilo, hi, lo, 64'h0, 2'b00};
    end else if (!s[4]) begin
      model = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, hl, cn};
    end
    exp_q.push_back(model);
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        a_mon = '{mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o};
        checks++;
        if (a_mon !== e_mon) begin
          errors++;
          $display("FAIL outputs t=%0t got=%h exp=%h", $time, a_mon, e_mon);
        end
      end
    end
  end

  initial begin
    logic [5:0] s;
    logic       r;
    logic       f;
    rst = 1'b1; flush = 1'b0; stall = '0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0;
    ex_hi = '0; ex_lo = '0; hilo_i = '0; cnt_i = '0;

    // Reset overrides live execute data.
    step(1, 0, 6'b000000, 5'd3, 1, 32'hDEADBEEF, 1, 32'h11, 32'h22, 64'h5, 2'b11);
    // Pass.
    step(0, 0, 6'b000000, 5'd8, 1, 32'h12345678, 0, 32'h0, 32'h0, 64'h0, 2'b00);
    // Bubble carries madd feedback, then pass clears it.
    step(0, 0, 6'b001111, 5'd9, 1, 32'hCAFEF00D, 1, 32'h1, 32'h2, 64'h1_0000_0002, 2'b01);
    step(0, 0, 6'b001111, 5'd9, 1, 32'hCAFEF00D, 1, 32'h1, 32'h2, 64'h3_0000_0004, 2'b10);
    step(0, 0, 6'b000000, 5'd10, 0, 32'h0BADCAFE, 1, 32'h33, 32'h44, 64'h7, 2'b11);
    // Load, then hold for three edges with changing inputs.
    step(0, 0, 6'b000000, 5'd12, 1, 32'hA5A5A5A5, 0, 32'h0, 32'h0, 64'h0, 2'b00);
    for (int i = 0; i < 3; i++)
      step(0, 0, 6'b011111, 5'd0, 0, 32'h0, 1, 32'h99, 32'h98, 64'hFF, 2'b11);
    // Reset mid-hold, then resume.
    step(1, 0, 6'b011111, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0, 2'b00);
    step(0, 0, 6'b000000, 5'd17, 1, 32'h76543210, 1, 32'hAAAA, 32'hBBBB, 64'h0, 2'b00);
    // Flush during hold with HI/LO write pending (no-op in the default build).
    step(0, 1, 6'b011111, 5'd5, 1, 32'h5555, 1, 32'h66, 32'h77, 64'h88, 2'b01);
    step(0, 0, 6'b000000, 5'd6, 1, 32'h6666, 1, 32'h1, 32'h2, 64'h0, 2'b00);

    // Random phase biased toward the interesting stall patterns.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: s = 6'b000000;
        1: s = 6'b001111;
        2: s = 6'b011111;
        default: s = 6'($urandom);
      endcase
      r = ($urandom_range(0, 31) == 0);
      f = ($urandom_range(0, 15) == 0);
      step(r, f, s, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
           $urandom, $urandom, {$urandom, $urandom}, 2'($urandom));
    end
    driving_done = 1'b1;
  end

  // Wait for the scoreboard to drain, bounded.
  initial begin
    wait (driving_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
